// File: rtl/conv_pe_stream_mc.sv
// conv_pe_stream_mc: multi-channel strided KxK convolution PE.
// Raster pixel stream in, one signed sum per output position out.
module conv_pe_stream_mc #(
  parameter int KERNEL_SIZE = 3,
  parameter int FM_SIZE     = 8,
  parameter int CHANNELS    = 2,
  parameter int STRIDE      = 1,
  parameter int DATA_W      = 16,
  parameter int WEIGHT_W    = 18,
  parameter int ACC_W       = 48
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_load,
  input  logic                         i_w_valid,
  input  logic [WEIGHT_W-1:0]          i_w_data,
  input  logic                         i_valid,
  input  logic [CHANNELS*DATA_W-1:0]   i_data,
  output logic                         o_w_loaded,
  output logic                         o_valid,
  output logic [ACC_W-1:0]             o_P,
  output logic [$clog2(FM_SIZE)-1:0]   o_row,
  output logic [$clog2(FM_SIZE)-1:0]   o_col,
  output logic                         o_frame_done,
  output logic                         o_err
);
  localparam int K   = KERNEL_SIZE;
  localparam int W   = FM_SIZE;
  localparam int C   = CHANNELS;
  localparam int S   = STRIDE;
  localparam int KK  = K * K;
  localparam int NW  = C * KK;
  localparam int OUT = (W - K) / S + 1;
  localparam int PW  = DATA_W + WEIGHT_W;
  localparam int CW  = $clog2(W);
  localparam int WIW = (NW > 1) ? $clog2(NW) : 1;
  localparam int LB  = (K > 1) ? K - 1 : 1;

  typedef enum logic {LOAD, RUN} state_t;
  state_t state, state_n;

  logic [WIW-1:0] wcnt;
  logic [CW-1:0] x, y;
  logic signed [WEIGHT_W-1:0] wt [NW];
  logic signed [DATA_W-1:0] pix [C];
  logic signed [DATA_W-1:0] lb [C][LB][W];
  logic signed [DATA_W-1:0] win [C][K][K];
  logic signed [DATA_W-1:0] win_n [C][K][K];
  logic signed [PW-1:0] prod [NW];
  logic signed [ACC_W-1:0] sum;
  logic v1, last1, last_f;
  logic [CW-1:0] row1, col1, row_f, col_f;
  logic busy, load_ok, load_go, w_wr, acc, fire;

  always_comb begin
    busy    = v1 || o_valid;
    load_ok = (state == RUN) && (x == '0) && (y == '0) && !busy;
    load_go = i_load && load_ok;
    w_wr    = (state == LOAD) && i_w_valid;
    acc     = (state == RUN) && i_valid && !load_go;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= LOAD;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      LOAD: if (w_wr && wcnt == WIW'(NW - 1)) state_n = RUN;
      RUN:  if (load_go) state_n = LOAD;
    endcase
  end

  always_comb begin
    o_w_loaded = (state == RUN);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wcnt  <= '0;
      x     <= '0;
      y     <= '0;
      o_err <= 1'b0;
    end else begin
      if (w_wr)
        wcnt <= (wcnt == WIW'(NW - 1)) ? '0 : wcnt + WIW'(1);
      if ((state == LOAD && i_valid) ||
          (state == RUN && i_load && (!load_ok || i_valid)))
        o_err <= 1'b1;
      if (acc) begin
        if (x == CW'(W - 1)) begin
          x <= '0;
          y <= (y == CW'(W - 1)) ? '0 : y + CW'(1);
        end else begin
          x <= x + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NW; i++) wt[i] <= '0;
    end else if (w_wr) begin
      wt[wcnt] <= i_w_data;
    end
  end

  // lb[c][j][x] holds row y-1-j; window row r is feature-map row y-K+1+r
  always_comb begin
    for (int c = 0; c < C; c++) begin
      pix[c] = i_data[c*DATA_W +: DATA_W];
      for (int r = 0; r < K; r++)
        for (int k = 0; k < K - 1; k++)
          win_n[c][r][k] = win[c][r][k+1];
      for (int r = 0; r < K - 1; r++)
        win_n[c][r][K-1] = lb[c][K-2-r][x];
      win_n[c][K-1][K-1] = pix[c];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int c = 0; c < C; c++) begin
        for (int j = 0; j < LB; j++)
          for (int i = 0; i < W; i++) lb[c][j][i] <= '0;
        for (int r = 0; r < K; r++)
          for (int k = 0; k < K; k++) win[c][r][k] <= '0;
      end
    end else if (acc) begin
      win <= win_n;
      if (K > 1) begin
        for (int c = 0; c < C; c++) begin
          lb[c][0][x] <= pix[c];
          for (int j = 1; j < K - 1; j++) lb[c][j][x] <= lb[c][j-1][x];
        end
      end
    end
  end

  always_comb begin
    int dx, dy;
    dx     = int'(x) - (K - 1);
    dy     = int'(y) - (K - 1);
    fire   = acc && dx >= 0 && dy >= 0 && (dx % S == 0) && (dy % S == 0);
    row_f  = CW'(dy / S);
    col_f  = CW'(dx / S);
    last_f = (dy / S == OUT - 1) && (dx / S == OUT - 1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v1    <= 1'b0;
      last1 <= 1'b0;
      row1  <= '0;
      col1  <= '0;
      for (int i = 0; i < NW; i++) prod[i] <= '0;
    end else begin
      v1 <= fire;
      if (fire) begin
        row1  <= row_f;
        col1  <= col_f;
        last1 <= last_f;
        for (int c = 0; c < C; c++)
          for (int r = 0; r < K; r++)
            for (int k = 0; k < K; k++)
              prod[c*KK + r*K + k] <= PW'(win_n[c][r][k]) * PW'(wt[c*KK + r*K + k]);
      end
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < NW; i++) sum = sum + ACC_W'(prod[i]);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid      <= 1'b0;
      o_frame_done <= 1'b0;
      o_P          <= '0;
      o_row        <= '0;
      o_col        <= '0;
    end else begin
      o_valid      <= v1;
      o_frame_done <= v1 && last1;
      if (v1) begin
        o_P   <= sum;
        o_row <= row1;
        o_col <= col1;
      end
    end
  end

endmodule

// File: tb/tb_conv_pe_stream_mc.sv
// tb_conv_pe_stream_mc: five PE configurations checked cycle by cycle
// against an arithmetic convolution model with an output schedule.
module tb_conv_pe_stream_mc;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, load, w_valid, valid;
  logic [17:0] w_data;
  logic [47:0] data;
  int sel;

  logic wl [5];
  logic ov [5];
  logic fd [5];
  logic er [5];
  logic [47:0] op [5];
  logic [2:0] r0, c0, r1, c1, r3, c3;
  logic [1:0] r2, c2, r4, c4;

  logic d_wl, d_v, d_fd, d_err;
  logic [47:0] d_p;
  logic [7:0] d_row, d_col;

  int ck [5] = '{3, 3, 2, 3, 3};
  int cw [5] = '{5, 5, 3, 8, 3};
  int cc [5] = '{2, 2, 1, 3, 1};
  int cs [5] = '{1, 2, 1, 1, 1};

  conv_pe_stream_mc #(.KERNEL_SIZE(3), .FM_SIZE(5), .CHANNELS(2), .STRIDE(1)) u0 (
    .i_clk(clk), .i_rst(rst), .i_load(load && sel == 0),
    .i_w_valid(w_valid && sel == 0), .i_w_data(w_data),
    .i_valid(valid && sel == 0), .i_data(data[31:0]),
    .o_w_loaded(wl[0]), .o_valid(ov[0]), .o_P(op[0]), .o_row(r0), .o_col(c0),
    .o_frame_done(fd[0]), .o_err(er[0]));

  conv_pe_stream_mc #(.KERNEL_SIZE(3), .FM_SIZE(5), .CHANNELS(2), .STRIDE(2)) u1 (
    .i_clk(clk), .i_rst(rst), .i_load(load && sel == 1),
    .i_w_valid(w_valid && sel == 1), .i_w_data(w_data),
    .i_valid(valid && sel == 1), .i_data(data[31:0]),
    .o_w_loaded(wl[1]), .o_valid(ov[1]), .o_P(op[1]), .o_row(r1), .o_col(c1),
    .o_frame_done(fd[1]), .o_err(er[1]));

  conv_pe_stream_mc #(.KERNEL_SIZE(2), .FM_SIZE(3), .CHANNELS(1), .STRIDE(1)) u2 (
    .i_clk(clk), .i_rst(rst), .i_load(load && sel == 2),
    .i_w_valid(w_valid && sel == 2), .i_w_data(w_data),
    .i_valid(valid && sel == 2), .i_data(data[15:0]),
    .o_w_loaded(wl[2]), .o_valid(ov[2]), .o_P(op[2]), .o_row(r2), .o_col(c2),
    .o_frame_done(fd[2]), .o_err(er[2]));

  conv_pe_stream_mc #(.KERNEL_SIZE(3), .FM_SIZE(8), .CHANNELS(3), .STRIDE(1)) u3 (
    .i_clk(clk), .i_rst(rst), .i_load(load && sel == 3),
    .i_w_valid(w_valid && sel == 3), .i_w_data(w_data),
    .i_valid(valid && sel == 3), .i_data(data[47:0]),
    .o_w_loaded(wl[3]), .o_valid(ov[3]), .o_P(op[3]), .o_row(r3), .o_col(c3),
    .o_frame_done(fd[3]), .o_err(er[3]));

  conv_pe_stream_mc #(.KERNEL_SIZE(3), .FM_SIZE(3), .CHANNELS(1), .STRIDE(1)) u4 (
    .i_clk(clk), .i_rst(rst), .i_load(load && sel == 4),
    .i_w_valid(w_valid && sel == 4), .i_w_data(w_data),
    .i_valid(valid && sel == 4), .i_data(data[15:0]),
    .o_w_loaded(wl[4]), .o_valid(ov[4]), .o_P(op[4]), .o_row(r4), .o_col(c4),
    .o_frame_done(fd[4]), .o_err(er[4]));

  always_comb begin
    d_wl  = wl[sel];
    d_v   = ov[sel];
    d_fd  = fd[sel];
    d_err = er[sel];
    d_p   = op[sel];
    d_row = '0;
    d_col = '0;
    case (sel)
      0: begin d_row = 8'(r0); d_col = 8'(c0); end
      1: begin d_row = 8'(r1); d_col = 8'(c1); end
      2: begin d_row = 8'(r2); d_col = 8'(c2); end
      3: begin d_row = 8'(r3); d_col = 8'(c3); end
      4: begin d_row = 8'(r4); d_col = 8'(c4); end
      default: ;
    endcase
  end

  typedef struct {
    int     due;
    longint p;
    int     row;
    int     col;
    bit     fd;
  } exp_t;

  int K, W, C, S, NW, OUTN;
  int wt [27];
  int wstim [27];
  int pix [3][8][8];
  int stim [3][8][8];
  bit m_run, m_err;
  int m_wcnt, m_x, m_y, last_fire;
  exp_t q [$];
  longint l_p;
  int l_row, l_col;
  int cyc, n_cmp, n_bad, n_ov, const_p;
  bit use_const;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_out();
    bit ev, efd;
    ev  = 1'b0;
    efd = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      ev    = 1'b1;
      efd   = q[0].fd;
      l_p   = q[0].p;
      l_row = q[0].row;
      l_col = q[0].col;
      void'(q.pop_front());
    end
    if (d_v) n_ov++;
    chk("o_valid", d_v, ev);
    chk("o_frame_done", d_fd, efd);
    chk("o_P", d_p, l_p[47:0]);
    chk("o_row", d_row, l_row);
    chk("o_col", d_col, l_col);
    chk("o_w_loaded", d_wl, m_run);
    chk("o_err", d_err, m_err);
    if (use_const && d_v) chk("P_const", d_p, {16'b0, 48'(const_p)});
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check_out();
  endtask

  task automatic cycle(input bit ld, input bit wv, input int wd,
                       input bit v, input logic [47:0] d);
    int dx, dy;
    longint s;
    exp_t e;
    bit go, busy;
    load = ld; w_valid = wv; w_data = 18'(wd); valid = v; data = d;
    if (!m_run) begin
      if (v) m_err = 1'b1;
      if (wv) begin
        wt[m_wcnt] = wd;
        m_wcnt++;
        if (m_wcnt == NW) begin
          m_wcnt = 0;
          m_run  = 1'b1;
        end
      end
    end else begin
      busy = (cyc + 1 - last_fire) <= 2;
      go   = ld && m_x == 0 && m_y == 0 && !busy;
      if (ld && (!go || v)) m_err = 1'b1;
      if (go) m_run = 1'b0;
      else if (v) begin
        for (int ch = 0; ch < C; ch++)
          pix[ch][m_y][m_x] = int'($signed(d[ch*16 +: 16]));
        dx = m_x - (K - 1);
        dy = m_y - (K - 1);
        if (dx >= 0 && dy >= 0 && dx % S == 0 && dy % S == 0) begin
          s = 0;
          for (int ch = 0; ch < C; ch++)
            for (int r = 0; r < K; r++)
              for (int k = 0; k < K; k++)
                s += longint'(pix[ch][dy+r][dx+k]) * longint'(wt[ch*K*K + r*K + k]);
          e.due = cyc + 2;
          e.p   = s;
          e.row = dy / S;
          e.col = dx / S;
          e.fd  = (e.row == OUTN - 1) && (e.col == OUTN - 1);
          q.push_back(e);
          last_fire = cyc + 1;
        end
        if (m_x == W - 1) begin
          m_x = 0;
          m_y = (m_y == W - 1) ? 0 : m_y + 1;
        end else begin
          m_x++;
        end
      end
    end
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1; load = 1'b0; w_valid = 1'b0; valid = 1'b0;
    data = '0; w_data = '0;
    m_run = 1'b0; m_err = 1'b0; m_wcnt = 0; m_x = 0; m_y = 0;
    last_fire = -100;
    q.delete();
    l_p = 0; l_row = 0; l_col = 0;
    step();
    rst = 1'b0;
  endtask

  task automatic set_cfg(input int s_);
    sel = s_; K = ck[s_]; W = cw[s_]; C = cc[s_]; S = cs[s_];
    NW = C * K * K;
    OUTN = (W - K) / S + 1;
  endtask

  function automatic logic [47:0] pack(input int n);
    logic [47:0] v;
    v = '0;
    for (int ch = 0; ch < C; ch++) v[ch*16 +: 16] = 16'(stim[ch][n / W][n % W]);
    return v;
  endfunction

  task automatic flush(input int n);
    repeat (n) cycle(1'b0, 1'b0, 0, 1'b0, '0);
  endtask

  task automatic load_w();
    for (int i = 0; i < NW; i++) cycle(1'b0, 1'b1, wstim[i], 1'b0, '0);
  endtask

  task automatic drive_frame(input int gap, input int load_at, input int rst_at);
    int n;
    n = 0;
    while (n < W * W) begin
      if (gap > 0 && $urandom_range(99) < gap) begin
        cycle(1'b0, 1'b0, 0, 1'b0, '0);
      end else begin
        cycle(n == load_at, 1'b0, 0, 1'b1, pack(n));
        n++;
        if (n == rst_at) begin
          do_reset();
          return;
        end
      end
    end
  endtask

  task automatic fill_const(input int wv, input int pv);
    for (int i = 0; i < 27; i++) wstim[i] = wv;
    for (int ch = 0; ch < 3; ch++)
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) stim[ch][r][c] = pv;
  endtask

  task automatic rand_w();
    for (int i = 0; i < 27; i++) wstim[i] = int'($urandom_range(262143)) - 131072;
  endtask

  task automatic rand_px();
    for (int ch = 0; ch < 3; ch++)
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) stim[ch][r][c] = int'($urandom_range(65535)) - 32768;
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; w_valid = 1'b0; valid = 1'b0;
    w_data = '0; data = '0;
    cyc = 0; n_cmp = 0; n_bad = 0; n_ov = 0;
    use_const = 1'b0; const_p = 0;
    set_cfg(0);
    do_reset();

    // K=3 W=5 C=2 S=1, all ones
    fill_const(1, 1);
    load_w();
    n_ov = 0; use_const = 1'b1; const_p = 18;
    drive_frame(0, -1, -1);
    flush(3);
    chk("A_count", n_ov, 9);

    // same, stride 2
    set_cfg(1);
    do_reset();
    load_w();
    n_ov = 0;
    drive_frame(0, -1, -1);
    flush(3);
    chk("B_count", n_ov, 4);

    // signed check K=2 W=3 C=1
    set_cfg(2);
    do_reset();
    wstim[0] = 1; wstim[1] = -1; wstim[2] = 2; wstim[3] = -2;
    for (int i = 0; i < 9; i++) stim[0][i / 3][i % 3] = i;
    load_w();
    n_ov = 0; const_p = -3;
    drive_frame(0, -1, -1);
    flush(3);
    chk("C_count", n_ov, 4);
    use_const = 1'b0;

    // K=W: single output; load right after last pixel hits a busy pipe
    set_cfg(4);
    do_reset();
    rand_w(); rand_px();
    load_w();
    n_ov = 0;
    drive_frame(0, -1, -1);
    cycle(1'b1, 1'b0, 0, 1'b0, '0);
    flush(3);
    chk("D_count", n_ov, 1);
    chk("D_err_busy_load", d_err, 1'b1);
    cycle(1'b1, 1'b0, 0, 1'b0, '0);
    chk("D_reload_entered", d_wl, 1'b0);

    // K=3 W=8 C=3 random data, gap-free then gapped
    set_cfg(3);
    do_reset();
    rand_w(); rand_px();
    load_w();
    n_ov = 0;
    drive_frame(0, -1, -1);
    flush(3);
    chk("E_count_nogap", n_ov, 36);
    n_ov = 0;
    drive_frame(30, -1, -1);
    flush(3);
    chk("E_count_gap", n_ov, 36);
    chk("E_err_clean", d_err, 1'b0);

    // load mid-frame is ignored and flags an error
    n_ov = 0;
    drive_frame(0, 20, -1);
    flush(3);
    chk("E_count_midload", n_ov, 36);
    chk("E_err_midload", d_err, 1'b1);

    // load with a pixel at frame start, then a pixel during LOAD
    cycle(1'b1, 1'b0, 0, 1'b1, pack(0));
    chk("E_load_wins", d_wl, 1'b0);
    cycle(1'b0, 1'b0, 0, 1'b1, pack(0));
    rand_w();
    load_w();
    n_ov = 0;
    drive_frame(10, -1, -1);
    flush(3);
    chk("E_count_reload", n_ov, 36);
    chk("E_err_sticky", d_err, 1'b1);

    // reset mid-frame drops in-flight results
    n_ov = 0;
    drive_frame(0, -1, 13);
    flush(4);
    chk("E_rst_wl", d_wl, 1'b0);
    chk("E_rst_err", d_err, 1'b0);
    chk("E_rst_p", d_p, 48'd0);
    load_w();
    n_ov = 0;
    drive_frame(0, -1, -1);
    flush(3);
    chk("E_count_after_rst", n_ov, 36);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
